shift_register_univ: RTL

Parametrised universal shift register for the waterfall-light datapath; successor to the fixed 8-bit shift register.
- Width is generalised; modes are encoded on a 3-bit bus.
- Adds rotate modes, a ping-pong "bounce" mode with direction state, and a built-in step prescaler, so the LED pattern rate is set without an external clock divider.
- Sits between the system clock domain and the LED output pins.

---
 rtl/shift_register_univ.sv | 132 +++++++++++++
 1 files changed

// File: rtl/shift_register_univ.sv
// Universal shift register with shift/rotate/bounce/load modes and a built-in step prescaler.
// Optional WRAP_CNT_EN adds an 8-bit counter of rotate wrap-arounds and bounce reversals.
module shift_register_univ #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 4
) (
    input  logic             CP,
    input  logic             clr_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             DSR,
    input  logic             DSL,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             dir,
`ifdef WRAP_CNT_EN
    output logic [7:0]       wrap_cnt,
`endif
    output logic             tick
);

    localparam int unsigned WRAP_W = 8;

    localparam logic [2:0] MODE_SR     = 3'd1;
    localparam logic [2:0] MODE_SL     = 3'd2;
    localparam logic [2:0] MODE_RR     = 3'd3;
    localparam logic [2:0] MODE_RL     = 3'd4;
    localparam logic [2:0] MODE_BOUNCE = 3'd5;
    localparam logic [2:0] MODE_LOAD   = 3'd6;

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             dir_nxt;
    logic             step;
    logic             stepping_mode;
    logic             wrap_hit;
    logic [WIDTH-1:0] rot_r;
    logic [WIDTH-1:0] rot_l;

    assign rot_r         = {Q[0], Q[WIDTH-1:1]};
    assign rot_l         = {Q[WIDTH-2:0], Q[WIDTH-1]};
    assign stepping_mode = (mode >= MODE_SR) && (mode <= MODE_BOUNCE);

    // Prescaler and next-state datapath
    always_comb begin
        step     = 1'b0;
        cnt_nxt  = '0;
        q_nxt    = Q;
        dir_nxt  = dir;
        wrap_hit = 1'b0;

        // '>=' lets a lowered div take effect on the very next enabled cycle
        if (en && stepping_mode) begin
            if (cnt >= div) begin
                step = 1'b1;
            end else begin
                cnt_nxt = cnt + DIV_W'(1);
            end
        end

        if (en && (mode == MODE_LOAD)) begin
            q_nxt = D;
        end else if (step) begin
            case (mode)
                MODE_SR: q_nxt = {DSR, Q[WIDTH-1:1]};
                MODE_SL: q_nxt = {Q[WIDTH-2:0], DSL};
                MODE_RR: begin
                    q_nxt    = rot_r;
                    wrap_hit = Q[0];
                end
                MODE_RL: begin
                    q_nxt    = rot_l;
                    wrap_hit = Q[WIDTH-1];
                end
                MODE_BOUNCE: begin
                    // An all-zero pattern has no edge to bounce off, so it just sits
                    if (Q != '0) begin
                        if (!dir) begin
                            if (Q[WIDTH-1]) begin
                                dir_nxt  = 1'b1;
                                q_nxt    = rot_r;
                                wrap_hit = 1'b1;
                            end else begin
                                q_nxt = rot_l;
                            end
                        end else begin
                            if (Q[0]) begin
                                dir_nxt  = 1'b0;
                                q_nxt    = rot_l;
                                wrap_hit = 1'b1;
                            end else begin
                                q_nxt = rot_r;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers
    always_ff @(posedge CP or negedge clr_n) begin
        if (!clr_n) begin
            Q    <= '0;
            dir  <= 1'b0;
            tick <= 1'b0;
            cnt  <= '0;
        end else begin
            Q    <= q_nxt;
            dir  <= dir_nxt;
            tick <= step;
            cnt  <= cnt_nxt;
        end
    end

`ifdef WRAP_CNT_EN
    always_ff @(posedge CP or negedge clr_n) begin
        if (!clr_n) begin
            wrap_cnt <= '0;
        end else begin
            wrap_cnt <= wrap_cnt + WRAP_W'(wrap_hit);
        end
    end
`else
    logic unused_wrap;
    assign unused_wrap = wrap_hit;
`endif

endmodule
